// File: rtl/clock_tick_scheduler.sv
// Timebase and request scheduler for the clock's minutes/hours counters.
// Divides clkMSec into seconds and minutes, edge-detects set-mode buttons and
// turns both sources into single-cycle changeMin / changeHourSet pulses that
// are spaced so the downstream counter FSMs are back in IDLE before the next.
// Optional feature: define AUTOREPEAT_EN to build per-button hold counters that
// re-issue requests while a button is held in set mode.
module clock_tick_scheduler #(
  parameter int MS_PER_SEC  = 1000,
  parameter int SEC_PER_MIN = 60,
  parameter int MIN_GAP     = 4,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 200
) (
  input  logic       clkMSec,
  input  logic       resetN,
  input  logic       runEn,
  input  logic       setMode,
  input  logic       btnMin,
  input  logic       btnHour,
  input  logic       clrOverrun,
  output logic       changeMin,
  output logic       changeHourSet,
  output logic [5:0] secCount,
  output logic       overrun
);

  localparam int MS_W  = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
  localparam int GAP_W = $clog2(MIN_GAP);

  // The hold-counter reload needs REPEAT_MS <= HOLD_MS; secCount is 6 bits wide.
  if (MS_PER_SEC < 2 || SEC_PER_MIN < 2 || SEC_PER_MIN > 64 || MIN_GAP < 3 ||
      HOLD_MS < 1 || REPEAT_MS < 1 || REPEAT_MS > HOLD_MS) begin : g_bad_params
    $error("clock_tick_scheduler: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, PULSE_MIN, PULSE_HOUR, GAP} state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [MS_W-1:0]    ms_cnt_q, ms_cnt_d;
  logic [5:0]         sec_cnt_q, sec_cnt_d;
  logic               btn_min_q, btn_hour_q;
  logic               min_req_q, min_req_d;
  logic               hour_req_q, hour_req_d;
  logic               overrun_q, overrun_d;
  logic               min_tick;
  logic               rep_min, rep_hour;
  logic               min_raise, hour_raise;

  // Timebase: count enabled milliseconds, roll seconds, flag the minute wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    ms_cnt_d  = ms_cnt_q;
    sec_cnt_d = sec_cnt_q;
    min_tick  = 1'b0;
    if (setMode) begin
      ms_cnt_d  = '0;
      sec_cnt_d = '0;
    end else if (runEn) begin
      if (ms_cnt_q == MS_W'(MS_PER_SEC - 1)) begin
        ms_cnt_d = '0;
        if (sec_cnt_q == 6'(SEC_PER_MIN - 1)) begin
          sec_cnt_d = '0;
          min_tick  = 1'b1;
        end else begin
          sec_cnt_d = sec_cnt_q + 6'd1;
        end
      end else begin
        ms_cnt_d = ms_cnt_q + MS_W'(1);
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int HOLD_W = $clog2(HOLD_MS + 1);

  // Counter value k+1 means "held for k edges since the rising edge"; 0 means disarmed.
  function automatic logic [HOLD_W:0] hold_next(input logic lvl, input logic prev,
                                                input logic mode,
                                                input logic [HOLD_W-1:0] cnt);
    logic [HOLD_W-1:0] nxt;
    logic              rep;
    nxt = cnt;
    rep = 1'b0;
    if (!mode || !lvl) begin
      nxt = '0;
    end else if (!prev) begin
      nxt = HOLD_W'(1);
    end else if (cnt != '0) begin
      if (cnt == HOLD_W'(HOLD_MS)) begin
        rep = 1'b1;
        nxt = HOLD_W'(HOLD_MS + 1 - REPEAT_MS);
      end else begin
        nxt = cnt + HOLD_W'(1);
      end
    end
    return {rep, nxt};
  endfunction

  logic [HOLD_W-1:0] hold_min_q, hold_min_d, hold_hour_q, hold_hour_d;

  // Auto-repeat: advance both hold counters and emit repeat requests.
  always_comb begin
    {rep_min, hold_min_d}   = hold_next(btnMin, btn_min_q, setMode, hold_min_q);
    {rep_hour, hold_hour_d} = hold_next(btnHour, btn_hour_q, setMode, hold_hour_q);
  end

  // Hold counter registers.
  always_ff @(posedge clkMSec or negedge resetN) begin
    if (!resetN) begin
      hold_min_q  <= '0;
      hold_hour_q <= '0;
    end else begin
      hold_min_q  <= hold_min_d;
      hold_hour_q <= hold_hour_d;
    end
  end
`else
  assign rep_min  = 1'b0;
  assign rep_hour = 1'b0;
`endif

  assign min_raise  = min_tick | (setMode & btnMin & ~btn_min_q) | rep_min;
  assign hour_raise = (setMode & btnHour & ~btn_hour_q) | rep_hour;

  // Request latches and sticky overrun; a new request beats a same-edge clear.
  always_comb begin
    min_req_d  = min_raise  | (min_req_q  & (state_q != PULSE_MIN));
    hour_req_d = hour_raise | (hour_req_q & (state_q != PULSE_HOUR));
    overrun_d  = (min_raise & min_req_q) | (hour_raise & hour_req_q) |
                 (overrun_q & ~clrOverrun);
  end

  // Pulse sequencer: pick a pending request (minute first), pulse, then hold off.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (min_req_q)       state_d = PULSE_MIN;
        else if (hour_req_q) state_d = PULSE_HOUR;
      end
      PULSE_MIN, PULSE_HOUR: begin
        state_d   = GAP;
        gap_cnt_d = GAP_W'(MIN_GAP - 1);
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any pulse in flight and every pending request.
  always_ff @(posedge clkMSec or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      ms_cnt_q   <= '0;
      sec_cnt_q  <= '0;
      btn_min_q  <= 1'b0;
      btn_hour_q <= 1'b0;
      min_req_q  <= 1'b0;
      hour_req_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      ms_cnt_q   <= ms_cnt_d;
      sec_cnt_q  <= sec_cnt_d;
      btn_min_q  <= btnMin;
      btn_hour_q <= btnHour;
      min_req_q  <= min_req_d;
      hour_req_q <= hour_req_d;
      overrun_q  <= overrun_d;
    end
  end

  assign changeMin     = (state_q == PULSE_MIN);
  assign changeHourSet = (state_q == PULSE_HOUR);
  assign secCount      = sec_cnt_q;
  assign overrun       = overrun_q;

endmodule
